// File: rtl/mac_lanes_if.sv
// mac_lanes_if: operand/result handshake bundle for mac_lanes.
// The master drives operands and out_ready; the slave (the engine) drives
// in_ready and the result beat.
interface mac_lanes_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int ACC_W = 24
);
    logic                     in_valid;
    logic                     in_ready;
    logic [1:0]               in_op;
    logic                     in_last;
    logic [LANES*WIDTH-1:0]   in_x;
    logic [LANES*WIDTH-1:0]   in_y;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*ACC_W-1:0]   out_z;
    logic [LANES-1:0]         out_ovf;

    modport master (
        output in_valid, in_op, in_last, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_z, out_ovf
    );

    modport slave (
        input  in_valid, in_op, in_last, in_x, in_y, out_ready,
        output in_ready, out_valid, out_z, out_ovf
    );
endinterface

// File: rtl/mac_lanes.sv
// mac_lanes: LANES-wide two-stage add / multiply / multiply-accumulate engine
// with valid/ready handshakes and per-lane saturating accumulators.
// S1 computes the per-lane sum or product; S2 updates the accumulators and
// holds the result beat. Accumulator updates are committed when a beat moves
// from S1 into S2, so MAC-without-last and CLEAR beats never occupy S2.
// Optional feature: define MAC_LANES_SIGNED_EN for two's-complement operands,
// sign-extended results and signed saturation bounds.
module mac_lanes #(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int ACC_W = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    mac_lanes_if.slave  bus
);
    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_MULT  = 2'b01,
        OP_MAC   = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    localparam int ZW = LANES * ACC_W;

    generate
        if (ACC_W < 2 * WIDTH) begin : g_bad_acc_w
            $error("mac_lanes: ACC_W must be at least 2*WIDTH");
        end
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("mac_lanes: WIDTH must be in 2..32");
        end
        if (LANES < 1 || LANES > 16) begin : g_bad_lanes
            $error("mac_lanes: LANES must be in 1..16");
        end
    endgenerate

    logic            s1_valid_q, s1_valid_d;
    op_e             s1_op_q, s1_op_d;
    logic            s1_last_q, s1_last_d;
    logic [ZW-1:0]   s1_res_q, s1_res_d;
    logic            s2_valid_q, s2_valid_d;
    logic [ZW-1:0]   z_q, z_d;
    logic [LANES-1:0] ovf_q, ovf_d;
    logic [ZW-1:0]   acc_q, acc_d;
    logic [LANES-1:0] sticky_q, sticky_d;

    logic s1_ready, s2_ready, s1_adv, emit;

    assign s2_ready     = !s2_valid_q | bus.out_ready;
    assign s1_ready     = !s1_valid_q | s2_ready;
    assign s1_adv       = s1_valid_q & s2_ready;
    assign emit         = (s1_op_q == OP_ADD) || (s1_op_q == OP_MULT) ||
                          ((s1_op_q == OP_MAC) && s1_last_q);
    assign bus.in_ready = s1_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_z     = z_q;
    assign bus.out_ovf   = ovf_q;

    // S1 next state: capture an accepted beat and compute its per-lane sum or product.
    always_comb begin
        logic [WIDTH-1:0] x, y;
        logic [ACC_W-1:0] xe, ye;
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_last_d  = s1_last_q;
        s1_res_d   = s1_res_q;
        x  = '0;
        y  = '0;
        xe = '0;
        ye = '0;
        if (s1_ready) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_op_d   = op_e'(bus.in_op);
                s1_last_d = bus.in_last;
                for (int unsigned i = 0; i < LANES; i++) begin
                    x = bus.in_x[i*WIDTH +: WIDTH];
                    y = bus.in_y[i*WIDTH +: WIDTH];
`ifdef MAC_LANES_SIGNED_EN
                    xe = ACC_W'($signed(x));
                    ye = ACC_W'($signed(y));
`else
                    xe = ACC_W'(x);
                    ye = ACC_W'(y);
`endif
                    case (op_e'(bus.in_op))
                        OP_ADD:          s1_res_d[i*ACC_W +: ACC_W] = xe + ye;
                        OP_MULT, OP_MAC: s1_res_d[i*ACC_W +: ACC_W] = xe * ye;
                        default:         s1_res_d[i*ACC_W +: ACC_W] = '0;
                    endcase
                end
            end
        end
    end

    // S2 next state: accumulate with saturation, emit result beats, hold under stall.
    always_comb begin
        logic [ACC_W:0]   sum;
        logic [ACC_W-1:0] a, p, sat;
        logic             lane_ovf;
        acc_d      = acc_q;
        sticky_d   = sticky_q;
        z_d        = z_q;
        ovf_d      = ovf_q;
        s2_valid_d = s2_ready ? (s1_valid_q & emit) : s2_valid_q;
        for (int unsigned i = 0; i < LANES; i++) begin
            a = acc_q[i*ACC_W +: ACC_W];
            p = s1_res_q[i*ACC_W +: ACC_W];
`ifdef MAC_LANES_SIGNED_EN
            sum      = {a[ACC_W-1], a} + {p[ACC_W-1], p};
            lane_ovf = sum[ACC_W] ^ sum[ACC_W-1];
            sat      = lane_ovf ? (sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                              : {1'b0, {(ACC_W-1){1'b1}}})
                                : sum[ACC_W-1:0];
`else
            sum      = {1'b0, a} + {1'b0, p};
            lane_ovf = sum[ACC_W];
            sat      = lane_ovf ? '1 : sum[ACC_W-1:0];
`endif
            if (s1_adv) begin
                case (s1_op_q)
                    OP_ADD, OP_MULT: begin
                        z_d[i*ACC_W +: ACC_W] = p;
                        ovf_d[i]              = 1'b0;
                    end
                    OP_MAC: begin
                        if (s1_last_q) begin
                            z_d[i*ACC_W +: ACC_W]   = sat;
                            ovf_d[i]                = sticky_q[i] | lane_ovf;
                            acc_d[i*ACC_W +: ACC_W] = '0;
                            sticky_d[i]             = 1'b0;
                        end else begin
                            acc_d[i*ACC_W +: ACC_W] = sat;
                            sticky_d[i]             = sticky_q[i] | lane_ovf;
                        end
                    end
                    default: begin
                        acc_d[i*ACC_W +: ACC_W] = '0;
                        sticky_d[i]             = 1'b0;
                    end
                endcase
            end
        end
    end

    // Pipeline and accumulator registers; reset drops all in-flight beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= OP_ADD;
            s1_last_q  <= 1'b0;
            s1_res_q   <= '0;
            s2_valid_q <= 1'b0;
            z_q        <= '0;
            ovf_q      <= '0;
            acc_q      <= '0;
            sticky_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_last_q  <= s1_last_d;
            s1_res_q   <= s1_res_d;
            s2_valid_q <= s2_valid_d;
            z_q        <= z_d;
            ovf_q      <= ovf_d;
            acc_q      <= acc_d;
            sticky_q   <= sticky_d;
        end
    end
endmodule

// File: tb/tb_mac_lanes.sv
// tb_mac_lanes: directed and randomized checks of mac_lanes against a
// lane-by-lane arithmetic reference model and an in-order expected-result queue.
module tb_mac_lanes;
    localparam int WIDTH = 8;
    localparam int LANES = 4;
    localparam int ACC_W = 16;
    localparam int XW    = LANES * WIDTH;
    localparam int ZW    = LANES * ACC_W;
    localparam longint MAXV = (longint'(1) << ACC_W) - 1;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   out_cnt = 0;
    bit   rand_rdy = 0;
    logic [ZW-1:0]    last_z;
    logic [LANES-1:0] last_ovf;

    typedef struct {
        logic [ZW-1:0]    z;
        logic [LANES-1:0] ovf;
    } exp_t;

    exp_t   exp_q[$];
    longint acc_m[LANES];
    bit     sticky_m[LANES];

    mac_lanes_if #(.WIDTH(WIDTH), .LANES(LANES), .ACC_W(ACC_W)) bus ();

    mac_lanes #(.WIDTH(WIDTH), .LANES(LANES), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [ZW-1:0] got, input logic [ZW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [XW-1:0] rep(input int v);
        logic [XW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*WIDTH +: WIDTH] = WIDTH'(v);
        return r;
    endfunction

    function automatic logic [XW-1:0] lanes4(input int l0, input int l1, input int l2, input int l3);
        logic [XW-1:0] r;
        r = {WIDTH'(l3), WIDTH'(l2), WIDTH'(l1), WIDTH'(l0)};
        return r;
    endfunction

    // Reference model: plain per-lane arithmetic on each accepted beat.
    task automatic model_accept(input logic [1:0] op, input logic last,
                                input logic [XW-1:0] x, input logic [XW-1:0] y);
        exp_t   e;
        longint xv, yv, s;
        bit     ov;
        e.z   = '0;
        e.ovf = '0;
        for (int i = 0; i < LANES; i++) begin
            xv = longint'(x[i*WIDTH +: WIDTH]);
            yv = longint'(y[i*WIDTH +: WIDTH]);
            case (op)
                2'd0: e.z[i*ACC_W +: ACC_W] = ACC_W'(xv + yv);
                2'd1: e.z[i*ACC_W +: ACC_W] = ACC_W'(xv * yv);
                2'd2: begin
                    s  = acc_m[i] + xv * yv;
                    ov = 0;
                    if (s > MAXV) begin
                        s  = MAXV;
                        ov = 1;
                    end
                    if (last) begin
                        e.z[i*ACC_W +: ACC_W] = ACC_W'(s);
                        e.ovf[i]    = sticky_m[i] | ov;
                        acc_m[i]    = 0;
                        sticky_m[i] = 0;
                    end else begin
                        acc_m[i]    = s;
                        sticky_m[i] = sticky_m[i] | ov;
                    end
                end
                default: begin
                    acc_m[i]    = 0;
                    sticky_m[i] = 0;
                end
            endcase
        end
        if (op == 2'd0 || op == 2'd1 || (op == 2'd2 && last)) exp_q.push_back(e);
    endtask

    // Monitor: compare every presented result with the queue head, feed the model.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            for (int i = 0; i < LANES; i++) begin
                acc_m[i]    = 0;
                sticky_m[i] = 0;
            end
        end else if (clk == 1'b0) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 1'b1, 1'b0);
                end else begin
                    check("out_z", bus.out_z, exp_q[0].z);
                    check("out_ovf", bus.out_ovf, exp_q[0].ovf);
                    if (bus.out_ready) begin
                        last_z   = bus.out_z;
                        last_ovf = bus.out_ovf;
                        out_cnt++;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) model_accept(bus.in_op, bus.in_last, bus.in_x, bus.in_y);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [1:0] op, input logic last,
                        input logic [XW-1:0] x, input logic [XW-1:0] y);
        bit ok;
        ok = 0;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_last  = last;
        bus.in_x     = x;
        bus.in_y     = y;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1;
            step();
            if (ok) break;
        end
        bus.in_valid = 1'b0;
        bus.in_x     = $urandom;
        bus.in_y     = $urandom;
        bus.in_op    = 2'($urandom);
        if (!ok) check("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic drain();
        bit done;
        done = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.out_valid) done = 1;
            @(posedge clk);
            #1;
            if (done) break;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int cnt0;
        int acc_n;
        int v;
        bit got;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = 2'd0;
        bus.in_last   = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_z", bus.out_z, '0);
        check("rst_out_ovf", bus.out_ovf, '0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // ADD with lane-boundary values, two-cycle latency
        bus.in_valid = 1'b1;
        bus.in_op    = 2'd0;
        bus.in_last  = 1'b0;
        bus.in_x     = lanes4(255, 1, 0, 7);
        bus.in_y     = lanes4(1, 1, 0, 8);
        @(negedge clk);
        check("t1_in_ready", bus.in_ready, 1'b1);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("t1_lat1_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        check("t1_lat2_valid", bus.out_valid, 1'b1);
        check("t1_z", bus.out_z, {16'd15, 16'd0, 16'd2, 16'd256});
        check("t1_ovf", bus.out_ovf, '0);
        step();
        drain();

        // MULT back-to-back at full throughput
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                bus.in_valid = 1'b1;
                bus.in_op    = 2'd1;
                bus.in_x     = rep(k);
                bus.in_y     = rep(k);
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            if (k < 8) check("t2_in_ready", bus.in_ready, 1'b1);
            check("t2_out_valid", bus.out_valid, k >= 2);
            if (k >= 2) check("t2_lane0", bus.out_z[ACC_W-1:0], (k - 2) * (k - 2));
            step();
        end
        drain();

        // MAC over three beats, then a single-beat MAC
        cnt0 = out_cnt;
        send(2'd2, 1'b0, rep(2), rep(3));
        send(2'd2, 1'b0, rep(4), rep(5));
        send(2'd2, 1'b1, rep(6), rep(7));
        drain();
        check("t3_one_out", out_cnt - cnt0, 1);
        check("t3_z", last_z, {4{16'd68}});
        check("t3_ovf", last_ovf, '0);
        send(2'd2, 1'b1, rep(1), rep(1));
        drain();
        check("t3_single", last_z, {4{16'd1}});

        // MAC saturation and sticky flag, then a clean restart
        send(2'd2, 1'b0, rep(255), rep(255));
        send(2'd2, 1'b1, rep(255), rep(255));
        drain();
        check("t4_sat_z", last_z, {4{16'hFFFF}});
        check("t4_sat_ovf", last_ovf, 4'hF);
        send(2'd2, 1'b1, rep(2), rep(3));
        drain();
        check("t4_restart_z", last_z, {4{16'd6}});
        check("t4_restart_ovf", last_ovf, '0);

        // Backpressure during a MULT stream
        cnt0 = out_cnt;
        bus.out_ready = 1'b0;
        v = 1;
        bus.in_valid = 1'b1;
        bus.in_op    = 2'd1;
        bus.in_last  = 1'b0;
        bus.in_x     = rep(v);
        bus.in_y     = rep(v);
        acc_n = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            got = bus.in_ready;
            if (got) acc_n++;
            step();
            if (got) begin
                v++;
                bus.in_x = rep(v);
                bus.in_y = rep(v);
            end
        end
        check("t5_accepted", acc_n, 2);
        check("t5_in_ready_low", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        for (int j = 0; j < 4; j++) send(2'd1, 1'b0, rep(v + j), rep(v + j));
        drain();
        check("t5_out_count", out_cnt - cnt0, 6);

        // Reset in the middle of an accumulation
        send(2'd2, 1'b0, rep(5), rep(5));
        send(2'd2, 1'b0, rep(5), rep(5));
        #2;
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t6_rst_valid", bus.out_valid, 1'b0);
            check("t6_rst_ready", bus.in_ready, 1'b1);
            check("t6_rst_z", bus.out_z, '0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        send(2'd2, 1'b1, rep(3), rep(3));
        drain();
        check("t6_after_rst", last_z, {4{16'd9}});

        // Randomized mix of ops, idles and backpressure
        rand_rdy = 1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) step();
            end
            send(2'($urandom), 1'($urandom), XW'($urandom), XW'($urandom));
        end
        rand_rdy = 0;
        send(2'd3, 1'b0, '0, '0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
